disp_update_sched: RTL and testbench

DISP_UPDATE_SCHED -- requirements
Module: disp_update_sched

---
 rtl/disp_pkg.sv | 23 ++
 rtl/txt_select_lfsr.sv | 29 ++
 rtl/disp_update_sched.sv | 138 +++++++++++++
 tb/tb_disp_update_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants, FSM state type and text-index mapping for the display update scheduler.
// Imported by the scheduler top and its LFSR sub-module.
package disp_pkg;

    localparam logic [9:0] V_AV          = 10'd480;
    localparam logic [4:0] LFSR_SEED     = 5'b00011;
    localparam logic [3:0] TXT_MAP_LIMIT = 4'd10;
    localparam logic [3:0] DIGIT_MAX     = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // Fold a 4-bit LFSR nibble onto a text index in 1..9 (or 0..7 when out of range).
    function automatic logic [3:0] map_txt(input logic [3:0] v);
        if ((v != 4'd0) && (v < TXT_MAP_LIMIT)) begin
            return v;
        end
        return {1'b0, v[3:1]};
    endfunction

endpackage

// File: rtl/txt_select_lfsr.sv
// 5-bit LFSR that picks a new text-string index whenever the committed digit changes.
// The step strobe comes from the scheduler; the index register only moves with it.
module txt_select_lfsr
    import disp_pkg::*;
(
    input  logic       pixClk,
    input  logic       reset,
    input  logic       step,
    input  logic       digit_en,
    output logic [3:0] txt_select
);

    logic [4:0] q;
    logic [4:0] q_next;

    assign q_next = {q[3:0], q[4] ^ q[1]};

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            q          <= LFSR_SEED;
            txt_select <= 4'd0;
        end else if (step) begin
            q          <= q_next;
            txt_select <= digit_en ? map_txt(q_next[3:0]) : 4'd0;
        end
    end

endmodule

// File: rtl/disp_update_sched.sv
// Schedules digit/text updates for the video generator so they only land at vertical blanking,
// and runs a self-stepping demo after a long stretch of frames without requests.
module disp_update_sched
    import disp_pkg::*;
#(
    parameter logic [9:0]  V_AV        = disp_pkg::V_AV,
    parameter logic [15:0] IDLE_FRAMES = 16'd600,
    parameter logic [7:0]  DEMO_FRAMES = 8'd60
) (
    input  logic       pixClk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       reqValid,
    input  logic [3:0] reqDigit,
    input  logic       reqEn,
    output logic       reqReady,
    output logic [3:0] digit,
    output logic       digitEn,
    output logic [3:0] txtSelect,
    output logic       frameStart,
    output logic       demoActive
);

    state_t      state;
    logic [3:0]  pend_digit;
    logic        pend_en;
    logic [15:0] idle_cnt;
    logic [7:0]  demo_cnt;

    logic        accept;
    logic        user_commit;
    logic        idle_frame;
    logic        demo_step;
    logic        commit;
    logic        lfsr_step;
    logic [3:0]  new_digit;
    logic        new_en;

    assign reqReady    = (state == IDLE);
    assign accept      = (state == IDLE) && reqValid;
    assign user_commit = (state == PEND) && frameStart;
    assign idle_frame  = (state == IDLE) && frameStart && !accept;
    assign demo_step   = idle_frame && demoActive && ((demo_cnt + 8'd1) == DEMO_FRAMES);
    assign commit      = user_commit || demo_step;
    assign lfsr_step   = commit && ({new_digit, new_en} != {digit, digitEn});

    // NOTE: defaults first so no path through this block can leave a latch behind.
    always_comb begin
        new_digit = digit;
        new_en    = digitEn;
        if (user_commit) begin
            if (pend_digit > DIGIT_MAX) begin
                new_digit = 4'd0;
                new_en    = 1'b0;
            end else begin
                new_digit = pend_digit;
                new_en    = pend_en;
            end
        end else if (demo_step) begin
            new_digit = (digit == DIGIT_MAX) ? 4'd0 : digit + 4'd1;
            new_en    = 1'b1;
        end
    end

    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            frameStart <= 1'b0;
        end else begin
            frameStart <= (x == 10'd0) && (y == V_AV);
        end
    end

    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pend_digit <= 4'd0;
            pend_en    <= 1'b0;
            digit      <= 4'd0;
            digitEn    <= 1'b0;
        end else begin
            if (commit) begin
                digit   <= new_digit;
                digitEn <= new_en;
            end
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        pend_digit <= reqDigit;
                        pend_en    <= reqEn;
                        state      <= PEND;
                    end
                end
                PEND: begin
                    if (frameStart) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Demo entry is gated on the exact crossing so a saturated counter cannot retrigger it.
    always_ff @(posedge pixClk or posedge reset) begin
        if (reset) begin
            idle_cnt   <= 16'd0;
            demo_cnt   <= 8'd0;
            demoActive <= 1'b0;
        end else if (accept) begin
            idle_cnt   <= 16'd0;
            demoActive <= 1'b0;
        end else if (idle_frame) begin
            if (idle_cnt != 16'hFFFF) begin
                idle_cnt <= idle_cnt + 16'd1;
            end
            if (!demoActive) begin
                if ((idle_cnt != 16'hFFFF) && ((idle_cnt + 16'd1) == IDLE_FRAMES)) begin
                    demoActive <= 1'b1;
                    demo_cnt   <= 8'd0;
                end
            end else if (demo_step) begin
                demo_cnt <= 8'd0;
            end else begin
                demo_cnt <= demo_cnt + 8'd1;
            end
        end
    end

    txt_select_lfsr u_txt_select_lfsr (
        .pixClk     (pixClk),
        .reset      (reset),
        .step       (lfsr_step),
        .digit_en   (new_en),
        .txt_select (txtSelect)
    );

endmodule

// File: tb/tb_disp_update_sched.sv
// Directed bench for disp_update_sched: user commits at vertical blanking, LFSR text mapping,
// invalid digits, reset in PEND and demo mode with shortened idle/demo frame counts.
module tb_disp_update_sched;

    localparam logic [9:0] V_AV_TB = 10'd480;

    logic       pixClk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] x = 10'd5;
    logic [9:0] y = 10'd100;
    logic       reqValid = 1'b0;
    logic [3:0] reqDigit = 4'd0;
    logic       reqEn = 1'b0;
    logic       reqReady;
    logic [3:0] digit;
    logic       digitEn;
    logic [3:0] txtSelect;
    logic       frameStart;
    logic       demoActive;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 pixClk = ~pixClk;

    disp_update_sched #(
        .V_AV        (V_AV_TB),
        .IDLE_FRAMES (16'd3),
        .DEMO_FRAMES (8'd2)
    ) dut (
        .pixClk     (pixClk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .reqValid   (reqValid),
        .reqDigit   (reqDigit),
        .reqEn      (reqEn),
        .reqReady   (reqReady),
        .digit      (digit),
        .digitEn    (digitEn),
        .txtSelect  (txtSelect),
        .frameStart (frameStart),
        .demoActive (demoActive)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] d, input logic en, input logic [3:0] t);
        check(tag, {7'd0, digit, digitEn, txtSelect}, {7'd0, d, en, t});
    endtask

    task automatic tick();
        @(negedge pixClk);
    endtask

    // One vertical-blanking event; returns after the commit edge has passed.
    task automatic frame();
        x = 10'd0;
        y = V_AV_TB;
        tick();
        x = 10'd5;
        y = 10'd100;
        tick();
    endtask

    task automatic accept(input logic [3:0] d, input logic en);
        reqValid = 1'b1;
        reqDigit = d;
        reqEn    = en;
        tick();
        reqValid = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        check("rst_ready", reqReady, 1);
        check_out("rst_out", 4'd0, 1'b0, 4'd0);
        check("rst_frame", frameStart, 0);
        check("rst_demo", demoActive, 0);
        reset = 1'b0;
        tick();

        // Request at y=100 waits in PEND; a second offer while pending is ignored.
        accept(4'd7, 1'b1);
        check("pend_ready", reqReady, 0);
        check_out("pend_hold", 4'd0, 1'b0, 4'd0);
        reqValid = 1'b1;
        reqDigit = 4'd2;
        tick();
        tick();
        reqValid = 1'b0;
        check_out("pend_ignore", 4'd0, 1'b0, 4'd0);
        x = 10'd0;
        y = V_AV_TB;
        tick();
        x = 10'd5;
        y = 10'd100;
        check("fs_high", frameStart, 1);
        check_out("fs_precommit", 4'd0, 1'b0, 4'd0);
        tick();
        check("fs_low", frameStart, 0);
        check_out("commit_7", 4'd7, 1'b1, 4'd7);
        check("commit_ready", reqReady, 1);

        // Acceptance on the frameStart cycle itself commits one frame later.
        x = 10'd0;
        y = V_AV_TB;
        tick();
        reqValid = 1'b1;
        reqDigit = 4'd3;
        reqEn    = 1'b1;
        x = 10'd5;
        y = 10'd100;
        tick();
        reqValid = 1'b0;
        check("fsacc_ready", reqReady, 0);
        check_out("fsacc_hold", 4'd7, 1'b1, 4'd7);
        frame();
        check_out("fsacc_commit", 4'd3, 1'b1, 4'd7);

        // Same value again: LFSR and text index hold, proven by the later sequence.
        accept(4'd3, 1'b1);
        frame();
        check_out("same_commit", 4'd3, 1'b1, 4'd7);
        accept(4'd12, 1'b1);
        frame();
        check_out("bad_digit", 4'd0, 1'b0, 4'd0);
        accept(4'd2, 1'b1);
        frame();
        check_out("commit_2en", 4'd2, 1'b1, 4'd7);
        accept(4'd2, 1'b0);
        frame();
        check_out("commit_2dis", 4'd2, 1'b0, 4'd0);
        accept(4'd9, 1'b1);
        frame();
        check_out("commit_9", 4'd9, 1'b1, 4'd9);
        check("no_demo_yet", demoActive, 0);

        // Reset while pending drops the request.
        accept(4'd4, 1'b1);
        check("pend4_ready", reqReady, 0);
        reset = 1'b1;
        #1;
        check_out("midrst_out", 4'd0, 1'b0, 4'd0);
        check("midrst_ready", reqReady, 1);
        check("midrst_frame", frameStart, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("postrst_ready", reqReady, 1);
        frame();
        check_out("lost_req", 4'd0, 1'b0, 4'd0);
        check("demo_f1", demoActive, 0);

        // Demo mode: idle frames 2 and 3 after reset, then a step every 2 frames.
        frame();
        check("demo_f2", demoActive, 0);
        frame();
        check("demo_f3", demoActive, 1);
        check_out("demo_f3_out", 4'd0, 1'b0, 4'd0);
        frame();
        check_out("demo_f4_out", 4'd0, 1'b0, 4'd0);
        frame();
        check_out("demo_f5_out", 4'd1, 1'b1, 4'd7);
        for (int k = 2; k <= 10; k++) begin
            frame();
            frame();
            check("demo_step", {11'd0, digit, digitEn}, {11'd0, 4'(k % 10), 1'b1});
        end
        check("demo_still", demoActive, 1);

        // Any acceptance cancels demo mode on its own edge.
        accept(4'd5, 1'b1);
        check("demo_cleared", demoActive, 0);
        check("demo_acc_ready", reqReady, 0);
        check("demo_acc_hold", {11'd0, digit, digitEn}, {11'd0, 4'd0, 1'b1});
        frame();
        check("demo_user_5", {11'd0, digit, digitEn}, {11'd0, 4'd5, 1'b1});
        check("demo_off", demoActive, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
